nexys_input_cond: RTL and testbench
===================================

NEXYS_INPUT_COND -- requirements
Module: nexys_input_cond

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, the number of consecutive stable synchronized cycles required to accept a new input value; legal range 2..2^24.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock (SoC clock domain).
REQ-003 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port btn_i, input, 1 bit: raw asynchronous push-button pin.
REQ-005 SHALL have port sw_i, input, 16 bits: raw asynchronous slide-switch pins.
REQ-006 SHALL have port btn_level_o, output, 1 bit: debounced button level; this is the SoC button IRQ source.
REQ-007 SHALL have port btn_press_o, output, 1 bit: one-cycle pulse on each accepted 0->1 of btn_level_o.
REQ-008 SHALL have port btn_release_o, output, 1 bit: one-cycle pulse on each accepted 1->0 of btn_level_o.
REQ-009 SHALL have port sw_o, output, 16 bits: debounced switch vector that feeds the GPIO input bus.
REQ-010 SHALL have port sw_changed_o, output, 1 bit: one-cycle pulse when sw_o updates.

Function
REQ-011 SHALL pass btn_i and every sw_i bit through a two-flop synchronizer before any other logic uses it.
REQ-012 SHALL debounce the button and the 16-bit switch vector independently, each with its own counter and stable register.
REQ-013 Each debouncer SHALL be a 2-state FSM:
- STABLE: entered when the synchronized value s equals the stable register; counter held at 0.
- CHANGING: entered when s differs from the stable register; counter counts from 0.
REQ-014 In CHANGING, SHALL return to STABLE with counter cleared, and without changing the output, the cycle s equals the stable register again (glitch rejection).
REQ-015 In CHANGING, for the vector debouncer, SHALL restart the counter at 0 whenever s differs from its own value in the previous cycle.
REQ-016 In CHANGING, SHALL load the stable register with s and return to STABLE on the cycle after the counter reaches DEBOUNCE_CYCLES-1 with s still differing.
REQ-017 Total latency from a clean pin change to the output change SHALL be exactly 2 + DEBOUNCE_CYCLES clock cycles.
REQ-018 SHALL assert btn_press_o, btn_release_o and sw_changed_o in the same cycle the corresponding stable register changes, for exactly one cycle.
REQ-019 SHALL size the counter at $clog2(DEBOUNCE_CYCLES) bits; the counter SHALL never wrap or exceed DEBOUNCE_CYCLES-1.
REQ-020 A pin pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no output change and no pulse.
REQ-021 Simultaneous button and switch events SHALL be processed independently, with no priority and no added latency.
REQ-022 btn_press_o and btn_release_o SHALL never be high in the same cycle.

Reset
REQ-023 When rst_i is high at a clock edge, SHALL clear the synchronizer flops, counters and stable registers to 0 and put both FSMs in STABLE.
REQ-024 Output reset values SHALL be: btn_level_o=0, btn_press_o=0, btn_release_o=0, sw_o=16'h0000, sw_changed_o=0.
REQ-025 Reset asserted mid-debounce SHALL abort the count with no output pulse.
REQ-026 If an input is held non-zero through reset, SHALL accept it 2 + DEBOUNCE_CYCLES cycles after rst_i falls and emit the corresponding pulse.

Structure
REQ-027 Package nexys_input_pkg SHALL hold the DEBOUNCE_CYCLES default constant and the debouncer state enum (STABLE, CHANGING).
REQ-028 SHALL use one sub-module, input_debounce, parameterized by WIDTH and DEBOUNCE_CYCLES, and containing synchronizer, FSM, counter, stable register and change pulse.
REQ-029 nexys_input_cond SHALL instantiate input_debounce twice (WIDTH=1 for the button, WIDTH=16 for the switches) and derive the press/release pulses from the WIDTH=1 instance's change pulse and level.
REQ-030 SHALL contain no asynchronous reset, no latches and no clock gating.

Verification (DEBOUNCE_CYCLES=8)
REQ-031 Clean button press: btn_i 0->1 at cycle 0 and held -> btn_level_o=1 and btn_press_o=1 at cycle 10 only; btn_press_o=0 at cycle 11.
REQ-032 Glitch rejection: btn_i high for 5 cycles, then low -> btn_level_o stays 0, no pulses; same for sw_i[3] high for 7 cycles.
REQ-033 Bounce: btn_i toggles 1,0,1,0,1 one cycle each, then holds 1 -> single btn_press_o exactly 10 cycles after the final rise.
REQ-034 Switch vector: sw_i 16'h0000->16'hA5A5, with sw_i[0] changing again at cycle 4 -> sw_o=16'hA5A5 and sw_changed_o pulse 10 cycles after the cycle-4 change; exactly one pulse.
REQ-035 Reset mid-operation: rst_i high at cycle 6 of a press count -> no pulse, outputs 0; btn_i still held -> btn_press_o 10 cycles after rst_i falls.
REQ-036 Release and simultaneity: btn_i 1->0 at the same cycle as sw_i changes to 16'h0001 -> btn_release_o and sw_changed_o both pulse at cycle 10; btn_press_o stays 0.

Source files
------------

// File: rtl/nexys_input_pkg.sv
// Shared constants and types for the Nexys push-button / slide-switch input conditioning.
package nexys_input_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int unsigned SW_WIDTH                = 16;

  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } db_state_e;

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for a WIDTH-bit input vector.
// The stable value is replaced only after the synchronized vector holds one new value for DEBOUNCE_CYCLES cycles.
module input_debounce
  import nexys_input_pkg::*;
#(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] level_o,
  output logic             changed_o
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] stable_q;
  logic [CNT_W-1:0] cnt_q;
  db_state_e        state_q;
  logic             changed_q;

  // Metastability guard for the asynchronous pins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // cnt_q holds how many consecutive cycles the current differing value has already been seen,
  // so the first differing cycle is counted on entry and acceptance lands 2 + DEBOUNCE_CYCLES after the pin.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= STABLE;
      cnt_q     <= '0;
      stable_q  <= '0;
      prev_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      prev_q    <= sync2_q;
      changed_q <= 1'b0;
      case (state_q)
        STABLE: begin
          if (sync2_q != stable_q) begin
            state_q <= CHANGING;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        CHANGING: begin
          if (sync2_q == stable_q) begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end else if (sync2_q != prev_q) begin
            cnt_q <= CNT_W'(1);
          end else if (cnt_q == CNT_LAST) begin
            stable_q  <= sync2_q;
            changed_q <= 1'b1;
            state_q   <= STABLE;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= STABLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o   = stable_q;
  assign changed_o = changed_q;

endmodule

// File: rtl/nexys_input_cond.sv
// Conditions the raw Nexys button and slide switches into debounced levels and edge pulses for the SoC.
module nexys_input_cond
  import nexys_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                btn_i,
  input  logic [SW_WIDTH-1:0] sw_i,
  output logic                btn_level_o,
  output logic                btn_press_o,
  output logic                btn_release_o,
  output logic [SW_WIDTH-1:0] sw_o,
  output logic                sw_changed_o
);

  logic btn_changed;

  input_debounce #(
    .WIDTH           (1),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .raw_i     (btn_i),
    .level_o   (btn_level_o),
    .changed_o (btn_changed)
  );

  input_debounce #(
    .WIDTH           (SW_WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .raw_i     (sw_i),
    .level_o   (sw_o),
    .changed_o (sw_changed_o)
  );

  // Both terms are flop outputs; the new level tells the direction of the accepted edge.
  assign btn_press_o   = btn_changed & btn_level_o;
  assign btn_release_o = btn_changed & ~btn_level_o;

endmodule

// File: tb/tb_nexys_input_cond.sv
// Randomized and directed bench for nexys_input_cond against a window-based reference model.
module tb_nexys_input_cond;

  localparam int unsigned D = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn;
  logic [15:0] sw;
  logic        btn_level_o;
  logic        btn_press_o;
  logic        btn_release_o;
  logic [15:0] sw_o;
  logic        sw_changed_o;

  always #5 clk = ~clk;

  nexys_input_cond #(.DEBOUNCE_CYCLES(D)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .btn_i         (btn),
    .sw_i          (sw),
    .btn_level_o   (btn_level_o),
    .btn_press_o   (btn_press_o),
    .btn_release_o (btn_release_o),
    .sw_o          (sw_o),
    .sw_changed_o  (sw_changed_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: a pin reaches the debouncer two cycles later; a value is accepted
  // once the last D synchronized samples all equal it and it differs from the current output.
  bit          model_valid = 0;
  logic        m_level, m_press, m_release, m_sw_chg;
  logic [15:0] m_sw;
  logic        p1_btn, p2_btn;
  logic [15:0] p1_sw, p2_sw;
  logic        btn_win[$];
  logic [15:0] sw_win[$];

  task automatic model_step(input logic r, input logic b, input logic [15:0] s);
    bit acc_b, acc_s;
    if (r) begin
      m_level = 0; m_press = 0; m_release = 0; m_sw_chg = 0; m_sw = '0;
      p1_btn = 0; p2_btn = 0; p1_sw = '0; p2_sw = '0;
      btn_win.delete();
      sw_win.delete();
      model_valid = 1;
      return;
    end
    btn_win.push_back(p2_btn);
    if (btn_win.size() > D) void'(btn_win.pop_front());
    sw_win.push_back(p2_sw);
    if (sw_win.size() > D) void'(sw_win.pop_front());
    acc_b = (btn_win.size() == D) && (p2_btn != m_level);
    foreach (btn_win[i]) if (btn_win[i] != p2_btn) acc_b = 0;
    acc_s = (sw_win.size() == D) && (p2_sw != m_sw);
    foreach (sw_win[i]) if (sw_win[i] != p2_sw) acc_s = 0;
    m_press   = acc_b && p2_btn;
    m_release = acc_b && !p2_btn;
    if (acc_b) m_level = p2_btn;
    m_sw_chg = acc_s;
    if (acc_s) m_sw = p2_sw;
    p2_btn = p1_btn; p1_btn = b;
    p2_sw  = p1_sw;  p1_sw  = s;
  endtask

  // Per-scenario event log, indexed by cycles since the scenario started.
  int scn_cycle, n_press, n_release, n_swchg, press_at, release_at, swchg_at;

  task automatic start_scn();
    scn_cycle = 0; n_press = 0; n_release = 0; n_swchg = 0;
    press_at = -1; release_at = -1; swchg_at = -1;
  endtask

  task automatic cycle(input logic r, input logic b, input logic [15:0] s);
    @(negedge clk);
    if (model_valid) begin
      check("btn_level", 32'(btn_level_o), 32'(m_level));
      check("btn_press", 32'(btn_press_o), 32'(m_press));
      check("btn_release", 32'(btn_release_o), 32'(m_release));
      check("sw", 32'(sw_o), 32'(m_sw));
      check("sw_changed", 32'(sw_changed_o), 32'(m_sw_chg));
      check("press_release_excl", 32'(btn_press_o & btn_release_o), 32'd0);
    end
    if (btn_press_o === 1'b1)   begin n_press++;   press_at   = scn_cycle; end
    if (btn_release_o === 1'b1) begin n_release++; release_at = scn_cycle; end
    if (sw_changed_o === 1'b1)  begin n_swchg++;   swchg_at   = scn_cycle; end
    rst = r; btn = b; sw = s;
    model_step(r, b, s);
    scn_cycle++;
  endtask

  task automatic hold(input int n, input logic r, input logic b, input logic [15:0] s);
    repeat (n) cycle(r, b, s);
  endtask

  initial begin
    logic [15:0] cur_sw;
    logic        cur_btn;
    int          len;
    rst = 1'b1; btn = 1'b0; sw = '0;
    hold(3, 1, 0, 16'h0000);
    start_scn();
    hold(20, 0, 0, 16'h0000);
    check("reset_no_pulses", 32'(n_press + n_release + n_swchg), 32'd0);
    check("reset_sw", 32'(sw_o), 32'd0);

    // Short pulses never reach the outputs.
    start_scn();
    hold(5, 0, 1, 16'h0000);
    hold(20, 0, 0, 16'h0000);
    check("glitch_btn_presses", 32'(n_press), 32'd0);
    check("glitch_btn_level", 32'(btn_level_o), 32'd0);
    start_scn();
    hold(7, 0, 0, 16'h0008);
    hold(20, 0, 0, 16'h0000);
    check("glitch_sw_changes", 32'(n_swchg), 32'd0);
    check("glitch_sw", 32'(sw_o), 32'd0);

    // Clean press.
    start_scn();
    hold(14, 0, 1, 16'h0000);
    check("press_count", 32'(n_press), 32'd1);
    check("press_cycle", 32'(press_at), 32'd10);
    check("press_level", 32'(btn_level_o), 32'd1);

    // Release together with a switch change.
    start_scn();
    hold(14, 0, 0, 16'h0001);
    check("simul_release_count", 32'(n_release), 32'd1);
    check("simul_release_cycle", 32'(release_at), 32'd10);
    check("simul_sw_count", 32'(n_swchg), 32'd1);
    check("simul_sw_cycle", 32'(swchg_at), 32'd10);
    check("simul_no_press", 32'(n_press), 32'd0);

    // Bounce 1,0,1,0,1 then hold.
    start_scn();
    cycle(0, 1, 16'h0001); cycle(0, 0, 16'h0001); cycle(0, 1, 16'h0001);
    cycle(0, 0, 16'h0001); cycle(0, 1, 16'h0001);
    hold(16, 0, 1, 16'h0001);
    check("bounce_press_count", 32'(n_press), 32'd1);
    check("bounce_press_cycle", 32'(press_at), 32'd14);
    hold(20, 0, 0, 16'h0000);

    // Vector with a late bit change restarting the count.
    start_scn();
    hold(4, 0, 0, 16'hA5A4);
    hold(14, 0, 0, 16'hA5A5);
    check("vec_change_count", 32'(n_swchg), 32'd1);
    check("vec_change_cycle", 32'(swchg_at), 32'd14);
    check("vec_value", 32'(sw_o), 32'h0000A5A5);

    // Reset in the middle of a press count, button held through it.
    start_scn();
    hold(6, 0, 1, 16'hA5A5);
    cycle(1, 1, 16'hA5A5);
    hold(20, 0, 1, 16'hA5A5);
    check("rst_mid_press_count", 32'(n_press), 32'd1);
    check("rst_mid_press_cycle", 32'(press_at), 32'd17);
    check("rst_mid_release_count", 32'(n_release), 32'd0);
    check("rst_mid_sw_after", 32'(sw_o), 32'h0000A5A5);

    // Random holds of varying length, with occasional resets.
    cur_sw = 16'hA5A5; cur_btn = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 1) == 0) cur_btn = ~cur_btn;
      if ($urandom_range(0, 3) == 0) cur_sw = 16'($urandom);
      else if ($urandom_range(0, 1) == 0) cur_sw = cur_sw ^ (16'h0001 << $urandom_range(0, 15));
      len = int'($urandom_range(1, 2 * D + 2));
      if ($urandom_range(0, 40) == 0) hold(1, 1, cur_btn, cur_sw);
      else hold(len, 0, cur_btn, cur_sw);
    end
    hold(2 * D + 4, 0, cur_btn, cur_sw);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
